// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI responder-side transmitter.
package spi_pkg;

  localparam int SPI_DW          = 12;
  localparam int SPI_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } spi_tx_state_t;

  // Bit counter width: must hold the value DW without wrapping.
  function automatic int spiCntWidth(input int dw);
    return $clog2(dw) + 1;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Brings one asynchronous SPI line into the clk domain and reports
// its synchronized level plus single-cycle rise/fall pulses.
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter int STAGES = SPI_SYNC_STAGES
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  // Chain resets low so a line already held low when reset releases (cs mid-frame) never looks like a new falling edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_level = r_sync[STAGES-1];
  assign o_rise  = r_sync[STAGES-1] & ~r_prev;
  assign o_fall  = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/spi_slave_tx.sv
// SPI responder transmitter: one-word holding buffer loaded over
// valid/ready, shifted out LSB first on miso during a cs-low frame.
module spi_slave_tx
  import spi_pkg::*;
#(
  parameter int DW          = SPI_DW,
  parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [DW-1:0] i_din,
  input  logic          i_din_valid,
  output logic          o_din_ready,
  input  logic          i_sclk,
  input  logic          i_cs,
  output logic          o_miso,
  output logic          o_miso_oe,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_underrun,
  output logic          o_aborted
);

  localparam int            CW       = spiCntWidth(DW);
  localparam logic [CW-1:0] LAST_BIT = CW'(DW - 1);

  spi_tx_state_t r_state;
  spi_tx_state_t w_nextState;

  logic          r_holdFull;
  logic [DW-1:0] r_hold;
  logic [DW-1:0] r_shift;
  logic [CW-1:0] r_bitCnt;
  logic          r_exitPending;
  logic          r_done;
  logic          r_underrun;
  logic          r_aborted;

  logic w_sclkLevel;
  logic w_sclkRise;
  logic w_sclkFall;
  logic w_csLevel;
  logic w_csRise;
  logic w_csFall;
  logic w_load;
  logic w_take;
  logic w_start;
  logic w_lastRise;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclkSync (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_async (i_sclk),
    .o_level (w_sclkLevel),
    .o_rise  (w_sclkRise),
    .o_fall  (w_sclkFall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_csSync (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_async (i_cs),
    .o_level (w_csLevel),
    .o_rise  (w_csRise),
    .o_fall  (w_csFall)
  );

  assign w_start     = (r_state == IDLE) && w_csFall;
  assign w_load      = i_din_valid && !r_holdFull;
  assign w_take      = w_start && r_holdFull;
  assign w_lastRise  = (r_state == SHIFT) && w_sclkRise && (r_bitCnt == LAST_BIT);
  assign o_din_ready = ~r_holdFull;

  // Holding buffer: a load only happens when empty, so it can never collide with a frame start draining it.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_holdFull <= 1'b0;
      r_hold     <= '0;
    end else if (w_load) begin
      r_holdFull <= 1'b1;
      r_hold     <= i_din;
    end else if (w_take) begin
      r_holdFull <= 1'b0;
    end
  end

  // Shift register and bit counter; the first falling sclk precedes any rise and must not shift bit 0 away.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_shift  <= '0;
      r_bitCnt <= '0;
    end else begin
      if (w_csFall) begin
        r_bitCnt <= '0;
      end else if ((r_state == SHIFT) && w_sclkRise) begin
        r_bitCnt <= r_bitCnt + 1'b1;
      end
      if (w_start) begin
        r_shift <= r_holdFull ? r_hold : '0;
      end else if ((r_state == SHIFT) && w_sclkFall && (r_bitCnt != '0)) begin
        r_shift <= r_shift >> 1;
      end
    end
  end

  // Status pulses, plus a one-cycle memo for cs rising together with the final sclk rise.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_done        <= 1'b0;
      r_underrun    <= 1'b0;
      r_aborted     <= 1'b0;
      r_exitPending <= 1'b0;
    end else begin
      r_done        <= w_lastRise;
      r_underrun    <= w_start && !r_holdFull;
      r_aborted     <= (r_state == SHIFT) && w_csRise && !w_lastRise;
      r_exitPending <= w_lastRise && w_csRise;
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // FSM next state: completing the word wins over a simultaneous cs release.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_csFall) w_nextState = SHIFT;
      end
      SHIFT: begin
        if (w_lastRise)    w_nextState = DONE;
        else if (w_csRise) w_nextState = IDLE;
      end
      DONE: begin
        if (w_csRise || r_exitPending) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // FSM outputs: miso is driven only inside a frame and is zero once the word is complete.
  always_comb begin
    o_miso    = 1'b0;
    o_miso_oe = 1'b0;
    o_busy    = 1'b0;
    case (r_state)
      SHIFT: begin
        o_miso    = r_shift[0];
        o_miso_oe = 1'b1;
        o_busy    = 1'b1;
      end
      DONE: begin
        o_miso_oe = 1'b1;
        o_busy    = 1'b1;
      end
      default: begin
        o_miso    = 1'b0;
        o_miso_oe = 1'b0;
        o_busy    = 1'b0;
      end
    endcase
  end

  assign o_done     = r_done;
  assign o_underrun = r_underrun;
  assign o_aborted  = r_aborted;

  // Synchronized levels are not needed by the control logic; folded here to keep every net consumed.
  logic w_unusedLevels;
  assign w_unusedLevels = w_sclkLevel ^ w_csLevel;

endmodule
